// File: rtl/regfile_mp.sv
// regfile_mp - parametrised multi-port register file for CGRA processing elements.
//
// Entries are zeroed by a hardware sweep after reset or on a clr request.
// While the sweep runs, ready is low, writes are ignored and every read port
// returns zero. Reads are combinational; writes commit on the rising edge.
// When several enabled ports write the same entry, the highest-index port wins.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   - a read that matches an enabled, non-dropped write in the same
//               cycle returns that write's data (highest-index port on ties)
//   undefined - reads always return the stored value
//
// Ports:
//   clk         in   clock, all state on the rising edge
//   rst_n       in   synchronous active-low reset
//   clr         in   request a full clear sweep
//   ready       out  1 = file usable, 0 while sweeping
//   we          in   [NUM_WR]        per-port write enable
//   wa          in   [NUM_WR*AW]     write addresses, port p at [p*AW +: AW]
//   wd          in   [NUM_WR*WIDTH]  write data, port p at [p*WIDTH +: WIDTH]
//   ra          in   [NUM_RD*AW]     read addresses, port r at [r*AW +: AW]
//   rd          out  [NUM_RD*WIDTH]  read data, combinational from ra
//   wr_conflict out  pulse: same-address write collision in the previous cycle
module regfile_mp #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clr,
   output logic                      ready,
   input  logic [NUM_WR-1:0]         we,
   input  logic [NUM_WR*$clog2(DEPTH)-1:0] wa,
   input  logic [NUM_WR*WIDTH-1:0]   wd,
   input  logic [NUM_RD*$clog2(DEPTH)-1:0] ra,
   output logic [NUM_RD*WIDTH-1:0]   rd,
   output logic                      wr_conflict
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] CNT_LAST = AW'(DEPTH - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t                   state_r, state_s;
   logic [AW-1:0]            cnt_r, cnt_s;
   logic                     ready_r, ready_s;
   logic                     wr_conflict_r, wr_conflict_s;
   logic [WIDTH-1:0]         mem_r [DEPTH];
   logic [NUM_RD*WIDTH-1:0]  rd_s;

   // Address 0 is a hardwired zero entry when ZERO_REG is set.
   function automatic logic is_dropped(input logic [AW-1:0] addr);
      return (ZERO_REG != 0) && (addr == {AW{1'b0}});
   endfunction

   // Any pair of enabled ports aiming at the same writable entry.
   function automatic logic detect_conflict(input logic [NUM_WR-1:0]    en,
                                            input logic [NUM_WR*AW-1:0] addr);
      logic hit;
      hit = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
         for (int q = p + 1; q < NUM_WR; q++) begin
            hit = hit | (en[p] && en[q] &&
                         (addr[p*AW +: AW] == addr[q*AW +: AW]) &&
                         !is_dropped(addr[p*AW +: AW]));
         end
      end
      return hit;
   endfunction

   // Sweep/run sequencing and the registered status outputs.
   always_comb begin
      state_s       = state_r;
      cnt_s         = cnt_r;
      ready_s       = ready_r;
      wr_conflict_s = 1'b0;
      case (state_r)
         ST_CLEAR: begin
            if (clr) begin
               cnt_s = {AW{1'b0}};
            end else if (cnt_r == CNT_LAST) begin
               state_s = ST_RUN;
               ready_s = 1'b1;
            end else begin
               cnt_s = cnt_r + AW'(1);
            end
         end
         ST_RUN: begin
            if (clr) begin
               state_s = ST_CLEAR;
               cnt_s   = {AW{1'b0}};
               ready_s = 1'b0;
            end else begin
               wr_conflict_s = detect_conflict(we, wa);
            end
         end
         default: begin
            state_s = ST_CLEAR;
            cnt_s   = {AW{1'b0}};
            ready_s = 1'b0;
         end
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= ST_CLEAR;
         cnt_r         <= {AW{1'b0}};
         ready_r       <= 1'b0;
         wr_conflict_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         cnt_r         <= cnt_s;
         ready_r       <= ready_s;
         wr_conflict_r <= wr_conflict_s;
      end
   end

   // Storage: sweep zeroing while clearing; ascending port loop makes the
   // highest-index enabled port the last assignment and thus the winner.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state_r == ST_CLEAR) begin
            mem_r[cnt_r] <= {WIDTH{1'b0}};
         end else if (!clr) begin
            for (int p = 0; p < NUM_WR; p++) begin
               if (we[p] && !is_dropped(wa[p*AW +: AW])) begin
                  mem_r[wa[p*AW +: AW]] <= wd[p*WIDTH +: WIDTH];
               end
            end
         end
      end
   end

   // Combinational read ports, forced to zero while sweeping.
   always_comb begin
      rd_s = {(NUM_RD*WIDTH){1'b0}};
      for (int r = 0; r < NUM_RD; r++) begin
         if (state_r != ST_RUN) begin
            rd_s[r*WIDTH +: WIDTH] = {WIDTH{1'b0}};
         end else if (is_dropped(ra[r*AW +: AW])) begin
            rd_s[r*WIDTH +: WIDTH] = {WIDTH{1'b0}};
         end else begin
            rd_s[r*WIDTH +: WIDTH] = mem_r[ra[r*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            // Later ports override earlier ones, matching commit priority.
            for (int p = 0; p < NUM_WR; p++) begin
               rd_s[r*WIDTH +: WIDTH] =
                  (we[p] && (wa[p*AW +: AW] == ra[r*AW +: AW])) ?
                  wd[p*WIDTH +: WIDTH] : rd_s[r*WIDTH +: WIDTH];
            end
`endif
         end
      end
   end

   assign rd          = rd_s;
   assign ready       = ready_r;
   assign wr_conflict = wr_conflict_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp with two write ports and two read ports.
module tb_regfile_mp;

   localparam int WIDTH  = 32;
   localparam int DEPTH  = 32;
   localparam int NUM_RD = 2;
   localparam int NUM_WR = 2;
   localparam int AW     = 5;

   logic                     clk   = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     clr   = 1'b0;
   logic [NUM_WR-1:0]        we    = '0;
   logic [NUM_WR*AW-1:0]     wa    = '0;
   logic [NUM_WR*WIDTH-1:0]  wd    = '0;
   logic [NUM_RD*AW-1:0]     ra    = '0;
   logic [NUM_RD*WIDTH-1:0]  rd;
   logic                     ready;
   logic                     wr_conflict;

   int errors = 0;
   int checks = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] exp_v;

   regfile_mp #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_REG(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready),
      .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd), .wr_conflict(wr_conflict)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      we[p] = 1'b1;
      wa[p*AW +: AW] = a;
      wd[p*WIDTH +: WIDTH] = d;
   endtask

   task automatic set_ra(input int r, input logic [AW-1:0] a);
      ra[r*AW +: AW] = a;
   endtask

   function automatic logic [WIDTH-1:0] rd_port(input int r);
      return rd[r*WIDTH +: WIDTH];
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; we = '0;
      repeat (3) @(posedge clk);
      #1;
      exp_q.push_back(32'd0);
      exp_v = exp_q.pop_front(); checks++;
      if (ready !== exp_v[0]) begin errors++; $display("FAIL reset_ready: got %b want %b", ready, exp_v[0]); end
      checks++;
      if (wr_conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b want 0", wr_conflict); end
      @(negedge clk) rst_n = 1'b1;
      for (int i = 1; i <= DEPTH; i++) begin
         set_ra(0, AW'($urandom_range(0, DEPTH - 1)));
         set_ra(1, AW'($urandom_range(0, DEPTH - 1)));
         exp_q.push_back((i == DEPTH) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
         exp_v = exp_q.pop_front(); checks++;
         if (ready !== exp_v[0]) begin errors++; $display("FAIL init_sweep_ready edge %0d: got %b want %b", i, ready, exp_v[0]); end
         exp_q.push_back(32'd0);
         exp_v = exp_q.pop_front(); checks++;
         if (rd_port(0) !== exp_v || rd_port(1) !== exp_v) begin
            errors++; $display("FAIL init_sweep_rd edge %0d: got %h/%h want %h", i, rd_port(0), rd_port(1), exp_v);
         end
      end
   endtask

   task automatic test_write_read();
      @(negedge clk); we = '0; set_wr(0, 5'd5, 32'hDEADBEEF);
      exp_q.push_back(32'hDEADBEEF);
      exp_q.push_back(32'hDEADBEEF);
      @(negedge clk); we = '0; set_ra(0, 5'd5); set_ra(1, 5'd5); #1;
      exp_v = exp_q.pop_front(); checks++;
      if (rd_port(0) !== exp_v) begin errors++; $display("FAIL write_read_p0: got %h want %h", rd_port(0), exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (rd_port(1) !== exp_v) begin errors++; $display("FAIL write_read_p1: got %h want %h", rd_port(1), exp_v); end
      checks++;
      if (wr_conflict !== 1'b0) begin errors++; $display("FAIL write_read_conflict: got %b want 0", wr_conflict); end
      set_wr(0, 5'd0, 32'h1234);
      exp_q.push_back(32'h0);
      @(negedge clk); we = '0; set_ra(0, 5'd0); #1;
      exp_v = exp_q.pop_front(); checks++;
      if (rd_port(0) !== exp_v) begin errors++; $display("FAIL zero_reg: got %h want %h", rd_port(0), exp_v); end
   endtask

   task automatic test_conflict();
      @(negedge clk); we = '0; set_wr(0, 5'd7, 32'h11); set_wr(1, 5'd7, 32'h22);
      exp_q.push_back(32'h22);
      @(negedge clk); we = '0; set_ra(0, 5'd7); #1;
      checks++;
      if (wr_conflict !== 1'b1) begin errors++; $display("FAIL conflict_pulse: got %b want 1", wr_conflict); end
      exp_v = exp_q.pop_front(); checks++;
      if (rd_port(0) !== exp_v) begin errors++; $display("FAIL conflict_priority: got %h want %h", rd_port(0), exp_v); end
      @(negedge clk); #1;
      checks++;
      if (wr_conflict !== 1'b0) begin errors++; $display("FAIL conflict_one_cycle: got %b want 0", wr_conflict); end
      // distinct addresses
      set_wr(0, 5'd8, 32'h33); set_wr(1, 5'd9, 32'h44);
      exp_q.push_back(32'h33); exp_q.push_back(32'h44);
      @(negedge clk); we = '0; set_ra(0, 5'd8); set_ra(1, 5'd9); #1;
      checks++;
      if (wr_conflict !== 1'b0) begin errors++; $display("FAIL distinct_conflict: got %b want 0", wr_conflict); end
      exp_v = exp_q.pop_front(); checks++;
      if (rd_port(0) !== exp_v) begin errors++; $display("FAIL distinct_p0: got %h want %h", rd_port(0), exp_v); end
      exp_v = exp_q.pop_front(); checks++;
      if (rd_port(1) !== exp_v) begin errors++; $display("FAIL distinct_p1: got %h want %h", rd_port(1), exp_v); end
      // both ports to the hardwired zero entry: no flag
      set_wr(0, 5'd0, 32'h5); set_wr(1, 5'd0, 32'h6);
      @(negedge clk); we = '0; #1;
      checks++;
      if (wr_conflict !== 1'b0) begin errors++; $display("FAIL zero_conflict: got %b want 0", wr_conflict); end
      // port 0 disabled with the same address: no collision, port 1 writes
      wa[0 +: AW] = 5'd7; wd[0 +: WIDTH] = 32'hEE; set_wr(1, 5'd7, 32'h99);
      exp_q.push_back(32'h99);
      @(negedge clk); we = '0; set_ra(0, 5'd7); #1;
      checks++;
      if (wr_conflict !== 1'b0) begin errors++; $display("FAIL disabled_conflict: got %b want 0", wr_conflict); end
      exp_v = exp_q.pop_front(); checks++;
      if (rd_port(0) !== exp_v) begin errors++; $display("FAIL disabled_port: got %h want %h", rd_port(0), exp_v); end
   endtask

   task automatic test_bypass();
      @(negedge clk); we = '0; set_wr(0, 5'd3, 32'hAA);
      @(negedge clk); we = '0; set_wr(0, 5'd3, 32'hBB); set_ra(0, 5'd3);
`ifdef REGFILE_BYPASS_EN
      exp_q.push_back(32'hBB);
`else
      exp_q.push_back(32'hAA);
`endif
      #1;
      exp_v = exp_q.pop_front(); checks++;
      if (rd_port(0) !== exp_v) begin errors++; $display("FAIL same_cycle_rw: got %h want %h", rd_port(0), exp_v); end
      exp_q.push_back(32'hBB);
      @(negedge clk); we = '0; #1;
      exp_v = exp_q.pop_front(); checks++;
      if (rd_port(0) !== exp_v) begin errors++; $display("FAIL rw_next_cycle: got %h want %h", rd_port(0), exp_v); end
      // two ports hit the read address; entry 12 still holds its swept zero
      set_wr(0, 5'd12, 32'h1); set_wr(1, 5'd12, 32'h2); set_ra(1, 5'd12);
`ifdef REGFILE_BYPASS_EN
      exp_q.push_back(32'h2);
`else
      exp_q.push_back(32'h0);
`endif
      #1;
      exp_v = exp_q.pop_front(); checks++;
      if (rd_port(1) !== exp_v) begin errors++; $display("FAIL bypass_priority: got %h want %h", rd_port(1), exp_v); end
      exp_q.push_back(32'h2);
      @(negedge clk); we = '0; #1;
      exp_v = exp_q.pop_front(); checks++;
      if (rd_port(1) !== exp_v) begin errors++; $display("FAIL priority_commit: got %h want %h", rd_port(1), exp_v); end
      // write to the zero entry never appears on a read
      set_wr(0, 5'd0, 32'h5); set_ra(0, 5'd0);
      exp_q.push_back(32'h0);
      #1;
      exp_v = exp_q.pop_front(); checks++;
      if (rd_port(0) !== exp_v) begin errors++; $display("FAIL zero_bypass: got %h want %h", rd_port(0), exp_v); end
      @(negedge clk); we = '0;
   endtask

   task automatic test_clear_cmd();
      @(negedge clk); we = '0; set_wr(0, 5'd9, 32'h55);
      exp_q.push_back(32'h55);
      @(negedge clk); we = '0; set_ra(0, 5'd9); #1;
      exp_v = exp_q.pop_front(); checks++;
      if (rd_port(0) !== exp_v) begin errors++; $display("FAIL clr_setup: got %h want %h", rd_port(0), exp_v); end
      @(negedge clk); clr = 1'b1; set_wr(0, 5'd9, 32'h77);
      // writes keep being presented through the sweep and must be ignored
      @(negedge clk); clr = 1'b0; set_wr(1, 5'd9, 32'h88); #1;
      checks++;
      if (ready !== 1'b0) begin errors++; $display("FAIL clr_ready_drop: got %b want 0", ready); end
      checks++;
      if (rd_port(0) !== 32'h0) begin errors++; $display("FAIL clr_rd_zero: got %h want 0", rd_port(0)); end
      for (int i = 1; i <= DEPTH; i++) begin
         exp_q.push_back((i == DEPTH) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
         exp_v = exp_q.pop_front(); checks++;
         if (ready !== exp_v[0]) begin errors++; $display("FAIL clr_sweep_ready edge %0d: got %b want %b", i, ready, exp_v[0]); end
         checks++;
         if (wr_conflict !== 1'b0) begin errors++; $display("FAIL clr_sweep_conflict edge %0d: got %b want 0", i, wr_conflict); end
         if (i < DEPTH) begin
            checks++;
            if (rd_port(0) !== 32'h0) begin errors++; $display("FAIL clr_sweep_rd edge %0d: got %h want 0", i, rd_port(0)); end
         end else begin
            we = '0;
         end
      end
      exp_q.push_back(32'h0);
      @(negedge clk); #1;
      exp_v = exp_q.pop_front(); checks++;
      if (rd_port(0) !== exp_v) begin errors++; $display("FAIL clr_mem9: got %h want %h", rd_port(0), exp_v); end
   endtask

   task automatic test_restart();
      // enter a sweep, advance to cnt=10, then reset for one edge
      @(negedge clk); we = '0; clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      for (int i = 1; i <= DEPTH; i++) begin
         exp_q.push_back((i == DEPTH) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
         exp_v = exp_q.pop_front(); checks++;
         if (ready !== exp_v[0]) begin errors++; $display("FAIL rst_restart_ready edge %0d: got %b want %b", i, ready, exp_v[0]); end
      end
      // enter a sweep, advance to cnt=20, then clr for one edge
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
      for (int i = 1; i <= DEPTH; i++) begin
         exp_q.push_back((i == DEPTH) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
         exp_v = exp_q.pop_front(); checks++;
         if (ready !== exp_v[0]) begin errors++; $display("FAIL clr_restart_ready edge %0d: got %b want %b", i, ready, exp_v[0]); end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_conflict();
      test_bypass();
      test_clear_cmd();
      test_restart();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file for CGRA processing elements, successor to the 2R1W scalar file. It has configurable width, depth and read/write port counts, an optional hardwired-zero entry and deterministic write-collision priority. A hardware clear sweep zeroes every entry after reset or on command, and a ready flag gates use. Reads are combinational; writes commit on the clock edge.

Parameters:
WIDTH, 32, data bits per entry
DEPTH, 32, number of entries (power of two, >=2); AW = $clog2(DEPTH) localparam
NUM_RD, 2, read ports
NUM_WR, 1, write ports (1..4)
ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
clr  in  1  request full clear sweep (sampled when rst_n=1)
ready  out  1  1 = file usable; 0 during clear sweep
we  in  NUM_WR  per-port write enable
wa  in  NUM_WR*AW  write addresses, port p at [p*AW +: AW]
wd  in  NUM_WR*WIDTH  write data, port p at [p*WIDTH +: WIDTH]
ra  in  NUM_RD*AW  read addresses, port r at [r*AW +: AW]
rd  out  NUM_RD*WIDTH  read data, combinational from ra
wr_conflict  out  1  one-cycle pulse: same-address write collision last cycle

Behaviour:
- FSM states: CLEAR, RUN. Sweep counter cnt is AW bits.
- rst_n=0 at edge: state<=CLEAR, cnt<=0, ready<=0, wr_conflict<=0. Memory is not reset directly; the sweep clears it.
- CLEAR, rst_n=1, edge: mem[cnt]<=0. If cnt==DEPTH-1, state<=RUN and ready<=1; else cnt<=cnt+1.
- ready rises on the DEPTH-th edge after rst_n goes high, e.g. DEPTH=32 -> 32 edges.
- clr=1 in RUN: next edge state<=CLEAR, cnt<=0, ready<=0. All writes presented in that cycle are discarded.
- clr=1 in CLEAR restarts the sweep (cnt<=0). rst_n=0 takes priority over clr.
- While state=CLEAR: all we ignored; all rd = 0 regardless of ra; wr_conflict held 0.
- RUN writes: each port p with we[p]=1 writes wd_p to mem[wa_p] at the edge.
  - ZERO_REG=1: writes to address 0 are dropped.
  - Same-address collision: the highest-index enabled port wins.
- wr_conflict: registered. It is 1 in the cycle after any two enabled ports target the same non-dropped address; otherwise 0. Address 0 with ZERO_REG=1 never flags.
- Reads: rd_r = mem[ra_r], latency 0. ZERO_REG=1 and ra_r==0 -> 0.
  - Read and write to the same address in the same cycle returns the old value (see optional feature).
- Unenabled write ports: wa/wd are don't-care, with no effect.
- Out-of-range addresses cannot occur (DEPTH is a power of two).

Optional Feature:
REGFILE_BYPASS_EN
- Defined: in RUN, if a read address matches an enabled, non-dropped write address in the same cycle, rd returns that write's wd, combinationally. On multiple matches, the highest-index port's data is returned, consistent with commit priority. No bypass during CLEAR; rd stays 0.
- Undefined: reads return the stored value only. The new data is visible from the cycle after the edge.

Test Plan:
1. rst_n=0 for 3 edges, then 1 (DEPTH=32) -> ready=0 for 31 edges, ready=1 after edge 32; every ra reads 0 throughout.
2. RUN, we[0]=1, wa=5, wd=32'hDEADBEEF; next cycle ra0=5 -> rd0=32'hDEADBEEF. Write wa=0, wd=32'h1234 -> ra=0 reads 0.
3. NUM_WR=2: both ports write addr 7, port0 32'h11, port1 32'h22 -> mem[7]=32'h22; wr_conflict=1 for exactly one cycle, then 0.
4. mem[3]=32'hAA. Write 32'hBB to 3 while ra0=3 in the same cycle -> rd0=32'hAA without macro, 32'hBB with REGFILE_BYPASS_EN; both read 32'hBB next cycle.
5. In RUN with mem[9]=32'h55, pulse clr together with a write to 9 -> ready=0 next cycle; rd=0 during sweep; after DEPTH edges ready=1 and mem[9]=0.
6. Mid-sweep (cnt=10), assert rst_n=0 for 1 edge -> cnt restarts at 0; ready rises DEPTH edges after release. clr at cnt=20 likewise restarts the sweep.
